// File: rtl/mux16_pkg.sv
// Shared constants and types for the registered 16:1 lane multiplexer.
package mux16_pkg;

    localparam int N_IN           = 16;
    localparam int SEL_W          = 4;
    localparam int N_CELL         = 4;
    localparam int LANES_PER_CELL = N_IN / N_CELL;

    typedef logic [SEL_W-1:0] sel_t;

endpackage : mux16_pkg

// File: rtl/mux_4to1.sv
// Combinational DW-wide 4:1 multiplexer cell; lane k occupies in[k*DW +: DW].
module mux_4to1 #(
    parameter int DW = 1
) (
    input  logic [4*DW-1:0] in,
    input  logic [1:0]      sel,
    output logic [DW-1:0]   out
);

    // Only the addressed lane reaches the output, so X/Z on the others is isolated.
    always_comb begin
        out = '0;
        case (sel)
            2'd0: out = in[0*DW +: DW];
            2'd1: out = in[1*DW +: DW];
            2'd2: out = in[2*DW +: DW];
            2'd3: out = in[3*DW +: DW];
            default: out = '0;
        endcase
    end

endmodule : mux_4to1

// File: rtl/mux_16to1.sv
// Registered 16:1 multiplexer built from five 4:1 cells (four first-level, one second-level).
// Optional MUX16_PIPE_EN inserts a register stage between the two levels (latency 2 instead of 1).
module mux_16to1
    import mux16_pkg::*;
#(
    parameter int DW = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_IN*DW-1:0] in,
    input  sel_t               sel,
    input  logic               in_valid,
    output logic [DW-1:0]      out,
    output logic               out_valid
);

    logic [N_CELL*DW-1:0] cell_out;
    logic [N_CELL*DW-1:0] stage_cells;
    logic [1:0]           stage_sel_hi;
    logic                 stage_valid;
    logic [DW-1:0]        result;

    for (genvar j = 0; j < N_CELL; j++) begin : g_cell
        mux_4to1 #(.DW(DW)) u_cell (
            .in  (in[j*LANES_PER_CELL*DW +: LANES_PER_CELL*DW]),
            .sel (sel[1:0]),
            .out (cell_out[j*DW +: DW])
        );
    end

`ifdef MUX16_PIPE_EN
    logic [N_CELL*DW-1:0] cell_q;
    logic [1:0]           sel_hi_q;
    logic                 valid_q;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of its inputs, whatever the statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cell_q   <= '0;
            sel_hi_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            cell_q   <= cell_out;
            sel_hi_q <= sel[3:2];
            valid_q  <= in_valid;
        end
    end

    assign stage_cells  = cell_q;
    assign stage_sel_hi = sel_hi_q;
    assign stage_valid  = valid_q;
`else
    assign stage_cells  = cell_out;
    assign stage_sel_hi = sel[3:2];
    assign stage_valid  = in_valid;
`endif

    mux_4to1 #(.DW(DW)) u_final (
        .in  (stage_cells),
        .sel (stage_sel_hi),
        .out (result)
    );

    // out only loads on a valid stage, so it holds its last result across idle cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out       <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= stage_valid;
            if (stage_valid) begin
                out <= result;
            end
        end
    end

endmodule : mux_16to1

// File: tb/tb_mux_16to1.sv
// Scoreboard bench for mux_16to1 (DW = 1); define MUX16_PIPE_EN for the two-cycle build.
module tb_mux_16to1;

`ifdef MUX16_PIPE_EN
    localparam int L = 2;
`else
    localparam int L = 1;
`endif

    typedef struct {
        logic data;
        int   due;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] in;
    logic [3:0]  sel;
    logic        in_valid;
    logic        out;
    logic        out_valid;

    exp_t sb[$];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    mux_16to1 #(.DW(1)) dut (
        .clk       (clk),
        .rst       (rst),
        .in        (in),
        .sel       (sel),
        .in_valid  (in_valid),
        .out       (out),
        .out_valid (out_valid)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: consumes one scoreboard entry per presented result.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (out_valid) begin
                if (sb.size() == 0) begin
                    check("spurious_out_valid", 32'(out_valid), 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("out", 32'(out), 32'(e.data));
                    check("latency", 32'(cyc), 32'(e.due));
                end
            end else if (sb.size() > 0 && sb[0].due <= cyc) begin
                e = sb.pop_front();
                check("missing_out_valid", 32'(out_valid), 32'd1);
            end
        end
    end

    // Drive one valid selection and record its expected result.
    task automatic issue(input logic [15:0] v, input logic [3:0] s, input logic e);
        exp_t x;
        in       = v;
        sel      = s;
        in_valid = 1'b1;
        x.data   = e;
        x.due    = cyc + L;
        sb.push_back(x);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    typedef struct {
        logic [3:0] s;
        logic       e;
    } vec_t;

    vec_t sweep[4] = '{'{4'h0, 1'b0}, '{4'h1, 1'b1}, '{4'h2, 1'b0}, '{4'hF, 1'b0}};

    initial begin
        logic [15:0] xv;

        // Reset asserted with in_valid high: outputs cleared and held.
        rst      = 1'b1;
        in_valid = 1'b1;
        in       = 16'hFFFF;
        sel      = 4'h0;
        #1;
        check("reset_out", 32'(out), 32'd0);
        check("reset_valid", 32'(out_valid), 32'd0);
        repeat (3) begin
            @(posedge clk);
            #1;
            check("reset_hold_out", 32'(out), 32'd0);
            check("reset_hold_valid", 32'(out_valid), 32'd0);
        end
        @(negedge clk);
        in_valid = 1'b0;
        rst      = 1'b0;
        @(posedge clk);
        #1;

        // Lane sweep on 16'h3F0A.
        foreach (sweep[i]) issue(16'h3F0A, sweep[i].s, sweep[i].e);
        idle(L + 2);

        // All selects back-to-back on 16'h8001.
        for (int s = 0; s < 16; s++) issue(16'h8001, 4'(s), (s == 0 || s == 15));
        idle(L + 2);

        // Hold: last result was 1; toggling inputs without in_valid must not disturb it.
        for (int k = 0; k < 4; k++) begin
            in       = (k % 2 == 0) ? 16'h0000 : 16'h7FFE;
            sel      = 4'(k * 5);
            in_valid = 1'b0;
            @(posedge clk);
            #3;
            check("hold_out", 32'(out), 32'd1);
            check("hold_valid", 32'(out_valid), 32'd0);
            #0;
        end
        @(posedge clk);
        #1;

        // Mid-stream asynchronous reset between clock edges.
        issue(16'hFFFF, 4'h3, 1'b1);
        issue(16'hFFFF, 4'h9, 1'b1);
        issue(16'hFFFF, 4'hC, 1'b1);
        #2;
        rst = 1'b1;
        sb.delete();
        #1;
        check("midrst_out", 32'(out), 32'd0);
        check("midrst_valid", 32'(out_valid), 32'd0);
        repeat (2) begin
            @(posedge clk);
            #1;
            check("midrst_hold_out", 32'(out), 32'd0);
            check("midrst_hold_valid", 32'(out_valid), 32'd0);
        end
        @(negedge clk);
        in_valid = 1'b0;
        rst      = 1'b0;
        @(posedge clk);
        #1;
        idle(L + 1);
        issue(16'hFFFF, 4'h7, 1'b1);
        idle(L + 2);

        // X isolation: only lane 0 is known.
        xv    = 16'bx;
        xv[0] = 1'b1;
        issue(xv, 4'h0, 1'b1);
        idle(L + 2);

        if (sb.size() != 0) check("scoreboard_drain", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Absolute time limit so the run always ends.
    initial begin
        #100000;
        $display("FAIL timeout actual=%0d required=<100000", $time);
        $fatal(1, "timeout");
    end

endmodule : tb_mux_16to1

// File: doc/mux_16to1.md
# mux_16to1

Registered 16:1 single-bit-lane multiplexer built structurally from 4:1 multiplexer cells (four first-level cells feeding one second-level cell). It is the common selection primitive in the datapath: one 16-lane input vector and a 4-bit select in, one lane out. It has a valid-qualified output, a clock, and an asynchronous active-high reset.

## Interface
- DW, default 1: width of each lane in bits. The `in` port is 16*DW bits and `out` is DW bits.
- clk  input  1  rising-edge clock.
- rst  input  1  reset, asynchronous, active-high.
- in  input  16*DW  lane vector. Lane k occupies in[k*DW +: DW].
- sel  input  4  lane index, 0..15.
- in_valid  input  1  qualifies `in` and `sel` on this cycle.
- out  output  DW  selected lane, registered.
- out_valid  output  1  `out` holds a result for an accepted in_valid.

## Operation
- Selection: `out` = lane `sel` of `in`.
- First level: cell j (j = 0..3) selects lane 4j + sel[1:0].
- Second level: selects the output of cell sel[3:2].
- Results use the in/sel values sampled on the in_valid cycle.
- When in_valid = 0:
  - `out` holds its last value.
  - out_valid drops to 0 for the matching output cycle.
- `sel` is always in range (4 bits, 16 lanes), so there is no out-of-range case.
- X/Z on unselected lanes must not affect `out`.

## Timing
- Reset: `out` = 0 and out_valid = 0, applied immediately on rst assertion regardless of clk.
- Reset mid-operation: any in-flight result (including the pipeline stage) is discarded. The first output after rst deasserts comes from the first in_valid sampled after deassertion.
- Default latency is 1 cycle:
  - in/sel/in_valid are sampled at edge N.
  - `out` and out_valid are updated after edge N.
- Throughput is one selection per cycle, back-to-back, with no stalls and no backpressure.
- Changing `sel` on consecutive valid cycles yields one independent result per cycle, in order.

## Configuration
- MUX16_PIPE_EN defined:
  - A register stage is inserted between the first-level and second-level cells.
  - sel[3:2] and in_valid are delayed alongside that stage.
  - Latency is 2 cycles; throughput is unchanged.
  - Pipeline registers reset to 0.
- MUX16_PIPE_EN undefined:
  - Both levels are combinational before the single output register.
  - Latency is 1 cycle.

## Structure
- Package mux16_pkg holds:
  - N_IN = 16
  - SEL_W = 4
  - N_CELL = 4
  - a typedef for the 4-bit select.
- Sub-module mux_4to1 (combinational, DW-wide, 4 lanes plus 2-bit select) is instantiated 5 times.
- No other sub-modules.

## Test plan
Latency L = 1, or 2 with MUX16_PIPE_EN. All scenarios use DW = 1.
- Reset: assert rst with in_valid = 1 -> out = 0 and out_valid = 0 immediately, held until release.
- Lane sweep with in = 16'h3F0A, in_valid = 1:
  - sel = 0 -> out = 0
  - sel = 1 -> out = 1
  - sel = 2 -> out = 0
  - sel = F -> out = 0
  - each result appears L cycles after its input, with out_valid = 1.
- Exhaustive check with in = 16'h8001:
  - all 16 sel values back-to-back -> out = 1 only for sel = 0 and sel = F, with one result per cycle.
- Hold behaviour: in_valid = 0 while in/sel toggle -> out unchanged and out_valid = 0.
- Mid-stream reset:
  - Pulse rst asynchronously between edges during a valid stream -> outputs clear immediately.
  - The next in_valid (in = 16'hFFFF, sel = 7) -> out = 1 after L cycles.
- X isolation: in = 16'bx...x1 (only bit 0 known), sel = 0 -> out = 1, never X.
